// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, size defaults
// and the running-checksum step.
package loader_pkg;

   localparam int MEM_DEPTH_DEF = 616;
   localparam int ADDR_W_DEF    = 10;
   localparam int WORD_W        = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CHECK  = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Packs payload bytes into big-endian 32-bit words and keeps the XOR checksum
// of every payload byte seen since the last clear.
module loader_word_assembler
   import loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_byte_en,
   input  logic [7:0]        i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_ready,
   output logic [7:0]        o_checksum
);

   // Only the three older bytes need storage; the fourth arrives with the pulse.
   logic [23:0] r_shift;
   logic [1:0]  r_byte_cnt;
   logic [7:0]  r_csum;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift    <= 24'd0;
         r_byte_cnt <= 2'd0;
         r_csum     <= 8'd0;
      end else if (i_clear) begin
         r_shift    <= 24'd0;
         r_byte_cnt <= 2'd0;
         r_csum     <= 8'd0;
      end else if (i_byte_en) begin
         r_shift    <= {r_shift[15:0], i_byte};
         r_byte_cnt <= r_byte_cnt + 2'd1;
         r_csum     <= csum_step(r_csum, i_byte);
      end else begin
         r_shift    <= r_shift;
         r_byte_cnt <= r_byte_cnt;
         r_csum     <= r_csum;
      end
   end

   assign o_word       = {r_shift, i_byte};
   assign o_word_ready = i_byte_en && (r_byte_cnt == 2'd3);
   assign o_checksum   = r_csum;

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed, checksummed byte stream into the instruction RAM,
// one registered write strobe per assembled word at consecutive addresses.
module instruction_loader
   import loader_pkg::*;
#(
   parameter int MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [WORD_W-1:0] i_ram_input,
   output logic [ADDR_W-1:0] i_ram_writing_address,
   output logic              flag_write_i_ram,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_len_hi;
   logic [15:0]         r_len;
   logic [ADDR_W:0]     r_word_idx;
   logic                r_byte_ready;
   logic                r_busy;
   logic                r_done;
   logic                r_error;
   logic                r_strobe;
   logic [WORD_W-1:0]   r_ram_data;
   logic [ADDR_W-1:0]   r_ram_addr;

   logic                w_accept;
   logic                w_start_ok;
   logic                w_data_en;
   logic [15:0]         w_len_rx;
   logic                w_len_bad;
   logic                w_last_word;
   logic [WORD_W-1:0]   w_word;
   logic                w_word_ready;
   logic [7:0]          w_checksum;
   logic                w_busy_nxt;
   logic                w_ready_nxt;
   logic                w_done_nxt;
   logic                w_err_nxt;

   assign w_accept    = byte_valid && r_byte_ready;
   assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
   assign w_data_en   = w_accept && (r_state == DATA);
   assign w_len_rx    = {r_len_hi, byte_in};
   assign w_len_bad   = (w_len_rx == 16'd0) || ({1'b0, w_len_rx} > 17'(MEM_DEPTH));
   assign w_last_word = ((17'(r_word_idx) + 17'd1) == {1'b0, r_len});

   loader_word_assembler u_asm (
      .clock        (clock),
      .reset        (reset),
      .i_clear      (w_start_ok),
      .i_byte_en    (w_data_en),
      .i_byte       (byte_in),
      .o_word       (w_word),
      .o_word_ready (w_word_ready),
      .o_checksum   (w_checksum)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE, ERR: begin
            if (start) w_state_nxt = LEN_HI;
            else       w_state_nxt = r_state;
         end
         LEN_HI: begin
            if (w_accept) w_state_nxt = LEN_LO;
            else          w_state_nxt = LEN_HI;
         end
         LEN_LO: begin
            if (w_accept) w_state_nxt = w_len_bad ? ERR : DATA;
            else          w_state_nxt = LEN_LO;
         end
         DATA: begin
            if (w_word_ready && w_last_word) w_state_nxt = CHECK;
            else                             w_state_nxt = DATA;
         end
         CHECK: begin
            if (w_accept) w_state_nxt = (byte_in == w_checksum) ? DONE : ERR;
            else          w_state_nxt = CHECK;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Status flags are decoded from the next state so they register in step with it.
   always_comb begin
      w_busy_nxt  = 1'b0;
      w_ready_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (w_state_nxt)
         LEN_HI, LEN_LO, DATA, CHECK: begin
            w_busy_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
         end
         DONE:    w_done_nxt = 1'b1;
         ERR:     w_err_nxt  = 1'b1;
         default: w_busy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_byte_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_byte_ready <= w_ready_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_err_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_len_hi   <= 8'd0;
         r_len      <= 16'd0;
         r_word_idx <= '0;
         r_strobe   <= 1'b0;
         r_ram_data <= '0;
         r_ram_addr <= '0;
      end else begin
         r_strobe <= w_word_ready;
         if (w_accept && (r_state == LEN_HI)) r_len_hi <= byte_in;
         else                                 r_len_hi <= r_len_hi;
         if (w_accept && (r_state == LEN_LO)) r_len <= w_len_rx;
         else                                 r_len <= r_len;
         if (w_start_ok)        r_word_idx <= '0;
         else if (w_word_ready) r_word_idx <= r_word_idx + IDX_ONE;
         else                   r_word_idx <= r_word_idx;
         if (w_word_ready) begin
            r_ram_data <= w_word;
            r_ram_addr <= r_word_idx[ADDR_W-1:0];
         end else begin
            r_ram_data <= r_ram_data;
            r_ram_addr <= r_ram_addr;
         end
      end
   end

   assign byte_ready            = r_byte_ready;
   assign busy                  = r_busy;
   assign done                  = r_done;
   assign error                 = r_error;
   assign flag_write_i_ram      = r_strobe;
   assign i_ram_input           = r_ram_data;
   assign i_ram_writing_address = r_ram_addr;

endmodule
